// File: rtl/zx_pkg.sv
// Shared types for the SDRAM slot arbiter: FSM states, slot owners,
// the latched CPU request and the default slot length.
package zx_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_RF,
    OWN_CPU,
    OWN_DMA
  } owner_t;

  typedef struct packed {
    logic        wr;
    logic [17:0] a;
    logic [7:0]  d;
  } cpu_req_t;

  localparam int CYCLE_DEF = 8;

endpackage

// File: rtl/sdram_arb_if.sv
// DMA loader handshake: request level held until the one-clock ack.
// The loader is the master, the arbiter is the slave.
interface sdram_arb_if #(
  parameter int DMAW = 24
);

  logic            dmaReq;
  logic            dmaWe;
  logic [DMAW-1:0] dmaA;
  logic [15:0]     dmaD;
  logic [15:0]     dmaQ;
  logic            dmaAck;

  modport master (
    output dmaReq, dmaWe, dmaA, dmaD,
    input  dmaQ, dmaAck
  );

  modport slave (
    input  dmaReq, dmaWe, dmaA, dmaD,
    output dmaQ, dmaAck
  );

endinterface

// File: rtl/sdram_arb_pending.sv
// One strobe latch: a strobe sets the flag and overwrites the payload,
// a grant clears the flag.
module arb_pending #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         set,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic         pend,
  output logic [W-1:0] dout
);

  // A strobe on its own grant clock is served live, so clear wins.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pend <= 1'b0;
      dout <= '0;
    end else if (clr) begin
      pend <= 1'b0;
    end else if (set) begin
      pend <= 1'b1;
      dout <= din;
    end
  end

endmodule

// File: rtl/sdram_arb.sv
// Fixed-priority SDRAM slot arbiter: refresh, then CPU, then DMA,
// one CYCLE-clock slot per grant.
module sdram_arb
  import zx_pkg::*;
#(
  parameter int CYCLE = CYCLE_DEF,
  parameter int DMAW  = 24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ready,
  input  logic        rfsh,
  input  logic        cpuRd,
  input  logic        cpuWr,
  input  logic [17:0] cpuA,
  input  logic [7:0]  cpuD,
  output logic [7:0]  cpuQ,
  sdram_arb_if.slave  dma,
  output logic        sdrRf,
  output logic        sdrRd,
  output logic        sdrWr,
  output logic [15:0] sdrD,
  output logic [23:0] sdrA,
  input  logic [15:0] sdrQ
);

  localparam logic [3:0] SC_LAST = 4'(CYCLE - 1);
  localparam logic [3:0] SC_ACK  = 4'(CYCLE - 2);
  localparam int         CW      = $bits(cpu_req_t);

  state_t          state;
  owner_t          owner;
  logic [3:0]      sc;
  logic            wr_q;
  logic            rf_pend;
  logic            rf_unused;
  logic            cpu_pend;
  logic [CW-1:0]   cpu_raw;
  logic            cpu_live;
  cpu_req_t        cpu_cur;
  logic            can_grant;
  logic            g_rf;
  logic            g_cpu;
  logic            g_dma;
  logic [DMAW-1:0] dma_a;

  assign dma_a    = dma.dmaA;
  assign cpu_live = cpuRd | cpuWr;

  // A fresh strobe beats the latched copy, and a joint rd+wr is a write.
  always_comb begin
    cpu_cur = cpu_req_t'(cpu_raw);
    if (cpu_live) begin
      cpu_cur = cpu_req_t'{wr: cpuWr, a: cpuA, d: cpuD};
    end
  end

  assign can_grant = ready && (state == IDLE);
  assign g_rf  = can_grant && (rf_pend || rfsh);
  assign g_cpu = can_grant && !(rf_pend || rfsh)
              && (cpu_pend || cpu_live);
  assign g_dma = can_grant && !(rf_pend || rfsh)
              && !(cpu_pend || cpu_live) && dma.dmaReq;

  arb_pending #(.W(1)) u_rf_pend (
    .clock (clock),
    .reset (reset),
    .set   (rfsh),
    .clr   (g_rf),
    .din   (1'b1),
    .pend  (rf_pend),
    .dout  (rf_unused)
  );

  arb_pending #(.W(CW)) u_cpu_pend (
    .clock (clock),
    .reset (reset),
    .set   (cpu_live),
    .clr   (g_cpu),
    .din   (cpu_req_t'{wr: cpuWr, a: cpuA, d: cpuD}),
    .pend  (cpu_pend),
    .dout  (cpu_raw)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      sc         <= '0;
      wr_q       <= 1'b0;
      sdrRf      <= 1'b0;
      sdrRd      <= 1'b0;
      sdrWr      <= 1'b0;
      sdrA       <= '0;
      sdrD       <= '0;
      cpuQ       <= '0;
      dma.dmaQ   <= '0;
      dma.dmaAck <= 1'b0;
    end else begin
      sdrRf      <= 1'b0;
      sdrRd      <= 1'b0;
      sdrWr      <= 1'b0;
      dma.dmaAck <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            g_rf: begin
              state <= BUSY;
              sc    <= '0;
              owner <= OWN_RF;
              wr_q  <= 1'b0;
              sdrRf <= 1'b1;
              sdrA  <= '0;
              sdrD  <= '0;
            end
            g_cpu: begin
              state <= BUSY;
              sc    <= '0;
              owner <= OWN_CPU;
              wr_q  <= cpu_cur.wr;
              sdrRd <= !cpu_cur.wr;
              sdrWr <= cpu_cur.wr;
              sdrA  <= {6'd0, cpu_cur.a};
              sdrD  <= {cpu_cur.d, cpu_cur.d};
            end
            g_dma: begin
              state <= BUSY;
              sc    <= '0;
              owner <= OWN_DMA;
              wr_q  <= dma.dmaWe;
              sdrRd <= !dma.dmaWe;
              sdrWr <= dma.dmaWe;
              sdrA  <= 24'(dma_a);
              sdrD  <= dma.dmaD;
            end
            default: ;
          endcase
        end
        BUSY: begin
          sc <= sc + 4'd1;
          // Ack one clock early so the loader can drop dmaReq in time.
          if (owner == OWN_DMA && sc == SC_ACK) begin
            dma.dmaAck <= 1'b1;
          end
          if (sc == SC_LAST) begin
            state <= IDLE;
            sc    <= '0;
            owner <= OWN_NONE;
            if (!wr_q && owner == OWN_CPU) begin
              cpuQ <= sdrQ[7:0];
            end
            if (!wr_q && owner == OWN_DMA) begin
              dma.dmaQ <= sdrQ;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arb.sv
// Scenario bench for sdram_arb: expected SDRAM commands are queued when
// stimulus is driven and checked as the arbiter issues them.
module tb_sdram_arb;
  import zx_pkg::*;

  localparam int CYC = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ready = 1'b0;
  logic        rfsh  = 1'b0;
  logic        cpuRd = 1'b0;
  logic        cpuWr = 1'b0;
  logic [17:0] cpuA  = '0;
  logic [7:0]  cpuD  = '0;
  logic [7:0]  cpuQ;
  logic        sdrRf, sdrRd, sdrWr;
  logic [15:0] sdrD;
  logic [23:0] sdrA;
  logic [15:0] sdrQ  = '0;

  sdram_arb_if #(.DMAW(24)) dma ();

  sdram_arb #(.CYCLE(CYC), .DMAW(24)) dut (
    .clock (clock),
    .reset (reset),
    .ready (ready),
    .rfsh  (rfsh),
    .cpuRd (cpuRd),
    .cpuWr (cpuWr),
    .cpuA  (cpuA),
    .cpuD  (cpuD),
    .cpuQ  (cpuQ),
    .dma   (dma),
    .sdrRf (sdrRf),
    .sdrRd (sdrRd),
    .sdrWr (sdrWr),
    .sdrD  (sdrD),
    .sdrA  (sdrA),
    .sdrQ  (sdrQ)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  cmd;
    logic [23:0] a;
    logic [15:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   gtime[$];
  int   total  = 0;
  int   bad    = 0;
  int   cyc    = 0;
  int   gcount = 0;
  int   acks   = 0;

  localparam logic [2:0] C_RF = 3'b100;
  localparam logic [2:0] C_RD = 3'b010;
  localparam logic [2:0] C_WR = 3'b001;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    exp_t e;
    if (dma.dmaAck === 1'b1) acks++;
    if (reset && (sdrRf || sdrRd || sdrWr)) begin
      gcount++;
      gtime.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_cmd got cmd=%b a=%h d=%h required none",
                 {sdrRf, sdrRd, sdrWr}, sdrA, sdrD);
      end else begin
        e = exp_q.pop_front();
        if ({sdrRf, sdrRd, sdrWr} !== e.cmd || sdrA !== e.a || sdrD !== e.d) begin
          bad++;
          $display("FAIL cmd got cmd=%b a=%h d=%h required cmd=%b a=%h d=%h",
                   {sdrRf, sdrRd, sdrWr}, sdrA, sdrD, e.cmd, e.a, e.d);
        end
      end
    end
  end

  function automatic exp_t mk(logic [2:0] c, logic [23:0] a, logic [15:0] d);
    exp_t e;
    e.cmd = c;
    e.a   = a;
    e.d   = d;
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_grants(input int n, input string name);
    int k = 0;
    while (gcount < n && k < 200) begin
      @(negedge clock);
      #1;
      k++;
    end
    total++;
    if (gcount < n) begin
      bad++;
      $display("FAIL %s_grant_timeout got=%0d required=%0d", name, gcount, n);
    end
  endtask

  task automatic wait_ack(input string name);
    int k = 0;
    while (dma.dmaAck !== 1'b1 && k < 200) begin
      @(negedge clock);
      #1;
      k++;
    end
    total++;
    if (dma.dmaAck !== 1'b1) begin
      bad++;
      $display("FAIL %s_ack_timeout got=%b required=1", name, dma.dmaAck);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ready = 1'b1;
    rfsh  = 1'b1;
    cpuRd = 1'b1;
    dma.dmaReq = 1'b1;
    repeat (3) tick();
    rfsh  = 1'b0;
    cpuRd = 1'b0;
    dma.dmaReq = 1'b0;
    @(negedge clock);
    total++;
    if ({cpuQ, dma.dmaQ, sdrA, sdrD, sdrRf, sdrRd, sdrWr, dma.dmaAck} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got q=%h dq=%h a=%h d=%h cmd=%b ack=%b required 0",
               cpuQ, dma.dmaQ, sdrA, sdrD, {sdrRf, sdrRd, sdrWr}, dma.dmaAck);
    end
    tick();
    reset = 1'b1;
    repeat (12) tick();
    total++;
    if (gcount !== 0) begin
      bad++;
      $display("FAIL reset_no_grant got=%0d required=0", gcount);
    end
  endtask

  task automatic test_cpu_read();
    int s, g0;
    g0   = gcount;
    sdrQ = 16'h00A5;
    exp_q.push_back(mk(C_RD, 24'h004000, 16'h0000));
    cpuA  = 18'h04000;
    cpuD  = 8'h00;
    cpuRd = 1'b1;
    tick();
    s = cyc;
    cpuRd = 1'b0;
    wait_grants(g0 + 1, "cpu_read");
    total++;
    if (gtime[g0] !== s) begin
      bad++;
      $display("FAIL cpu_read_latency got=%0d required=%0d", gtime[g0], s);
    end
    repeat (7) begin
      @(negedge clock);
      #1;
    end
    total++;
    if (cpuQ !== 8'h00 || sdrA !== 24'h004000) begin
      bad++;
      $display("FAIL cpu_read_sc7 got q=%h a=%h required q=00 a=004000", cpuQ, sdrA);
    end
    @(negedge clock);
    #1;
    total++;
    if (cpuQ !== 8'hA5) begin
      bad++;
      $display("FAIL cpu_read_data got=%h required=a5", cpuQ);
    end
  endtask

  task automatic test_contention();
    int g0, a0;
    g0 = gcount;
    a0 = acks;
    sdrQ = 16'h1234;
    exp_q.push_back(mk(C_RF, 24'h0, 16'h0));
    exp_q.push_back(mk(C_WR, 24'h000123, 16'h3C3C));
    exp_q.push_back(mk(C_RD, 24'h000777, 16'h9999));
    rfsh  = 1'b1;
    cpuWr = 1'b1;
    cpuA  = 18'h00123;
    cpuD  = 8'h3C;
    dma.dmaReq = 1'b1;
    dma.dmaWe  = 1'b0;
    dma.dmaA   = 24'h000777;
    dma.dmaD   = 16'h9999;
    tick();
    rfsh  = 1'b0;
    cpuWr = 1'b0;
    wait_ack("contention");
    tick();
    dma.dmaReq = 1'b0;
    wait_grants(g0 + 3, "contention");
    total++;
    if (gtime[g0 + 1] - gtime[g0] !== 9 || gtime[g0 + 2] - gtime[g0 + 1] !== 9) begin
      bad++;
      $display("FAIL contention_pitch got=%0d,%0d required=9,9",
               gtime[g0 + 1] - gtime[g0], gtime[g0 + 2] - gtime[g0 + 1]);
    end
    total++;
    if (dma.dmaQ !== 16'h1234 || cpuQ !== 8'hA5) begin
      bad++;
      $display("FAIL contention_data got dq=%h q=%h required dq=1234 q=a5",
               dma.dmaQ, cpuQ);
    end
    repeat (12) tick();
    total++;
    if (acks - a0 !== 1) begin
      bad++;
      $display("FAIL contention_acks got=%0d required=1", acks - a0);
    end
  endtask

  task automatic test_dma_write();
    int g0, a0, gt;
    g0 = gcount;
    a0 = acks;
    exp_q.push_back(mk(C_WR, 24'h100000, 16'hBEEF));
    dma.dmaReq = 1'b1;
    dma.dmaWe  = 1'b1;
    dma.dmaA   = 24'h100000;
    dma.dmaD   = 16'hBEEF;
    wait_grants(g0 + 1, "dma_write");
    gt = gtime[g0];
    wait_ack("dma_write");
    total++;
    if (cyc !== gt + CYC - 1) begin
      bad++;
      $display("FAIL dma_write_ack_time got=%0d required=%0d", cyc - gt, CYC - 1);
    end
    total++;
    if (sdrA !== 24'h100000 || sdrD !== 16'hBEEF) begin
      bad++;
      $display("FAIL dma_write_hold got a=%h d=%h required a=100000 d=beef", sdrA, sdrD);
    end
    tick();
    dma.dmaReq = 1'b0;
    repeat (15) tick();
    total++;
    if (acks - a0 !== 1) begin
      bad++;
      $display("FAIL dma_write_acks got=%0d required=1", acks - a0);
    end
  endtask

  task automatic test_busy_strobes();
    int g0;
    g0 = gcount;
    exp_q.push_back(mk(C_RD, 24'h000010, 16'h0000));
    exp_q.push_back(mk(C_RF, 24'h0, 16'h0));
    exp_q.push_back(mk(C_WR, 24'h000222, 16'h5A5A));
    cpuA  = 18'h00010;
    cpuD  = 8'h00;
    cpuRd = 1'b1;
    tick();
    cpuRd = 1'b0;
    wait_grants(g0 + 1, "busy");
    tick();
    rfsh = 1'b1;
    tick();
    rfsh = 1'b0;
    tick();
    rfsh = 1'b1;
    tick();
    rfsh  = 1'b0;
    cpuRd = 1'b1;
    cpuA  = 18'h00111;
    tick();
    cpuRd = 1'b0;
    cpuWr = 1'b1;
    cpuA  = 18'h00222;
    cpuD  = 8'h5A;
    tick();
    cpuWr = 1'b0;
    wait_grants(g0 + 3, "busy");
    total++;
    if (gtime[g0 + 1] - gtime[g0] !== 9) begin
      bad++;
      $display("FAIL busy_rf_pitch got=%0d required=9", gtime[g0 + 1] - gtime[g0]);
    end
    repeat (20) tick();
    total++;
    if (gcount !== g0 + 3 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL busy_grants got=%0d left=%0d required=%0d left=0",
               gcount - g0, exp_q.size(), 3);
    end
  endtask

  task automatic test_reset_abort();
    int g0, a0;
    g0 = gcount;
    sdrQ = 16'hFFFF;
    exp_q.push_back(mk(C_RD, 24'h000ABC, 16'h7777));
    dma.dmaReq = 1'b1;
    dma.dmaWe  = 1'b0;
    dma.dmaA   = 24'h000ABC;
    dma.dmaD   = 16'h7777;
    wait_grants(g0 + 1, "abort");
    a0 = acks;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    tick();
    tick();
    @(negedge clock);
    #1;
    total++;
    if ({cpuQ, dma.dmaQ, sdrA, sdrD, sdrRf, sdrRd, sdrWr, dma.dmaAck} !== '0
        || acks !== a0) begin
      bad++;
      $display("FAIL abort_outputs got q=%h dq=%h a=%h d=%h ack=%0d required 0",
               cpuQ, dma.dmaQ, sdrA, sdrD, acks - a0);
    end
    exp_q.push_back(mk(C_RD, 24'h000ABC, 16'h7777));
    tick();
    reset = 1'b1;
    wait_ack("abort");
    tick();
    dma.dmaReq = 1'b0;
    total++;
    if (dma.dmaQ !== 16'hFFFF || acks - a0 !== 1) begin
      bad++;
      $display("FAIL abort_rearb got dq=%h acks=%0d required dq=ffff acks=1",
               dma.dmaQ, acks - a0);
    end
    repeat (4) tick();
  endtask

  task automatic test_ready();
    int g0;
    g0 = gcount;
    ready = 1'b0;
    rfsh  = 1'b1;
    cpuRd = 1'b1;
    cpuWr = 1'b1;
    cpuA  = 18'h3FFFF;
    cpuD  = 8'h81;
    dma.dmaReq = 1'b1;
    dma.dmaWe  = 1'b1;
    dma.dmaA   = 24'h000042;
    dma.dmaD   = 16'h55AA;
    tick();
    rfsh  = 1'b0;
    cpuRd = 1'b0;
    cpuWr = 1'b0;
    repeat (20) tick();
    total++;
    if (gcount !== g0) begin
      bad++;
      $display("FAIL ready_low_grants got=%0d required=0", gcount - g0);
    end
    exp_q.push_back(mk(C_RF, 24'h0, 16'h0));
    exp_q.push_back(mk(C_WR, 24'h03FFFF, 16'h8181));
    exp_q.push_back(mk(C_WR, 24'h000042, 16'h55AA));
    ready = 1'b1;
    wait_grants(g0 + 1, "ready");
    ready = 1'b0;
    repeat (25) tick();
    total++;
    if (gcount !== g0 + 1) begin
      bad++;
      $display("FAIL ready_drop_grants got=%0d required=1", gcount - g0);
    end
    ready = 1'b1;
    wait_ack("ready");
    tick();
    dma.dmaReq = 1'b0;
    repeat (4) tick();
    total++;
    if (gcount !== g0 + 3 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL ready_order got=%0d left=%0d required=3 left=0",
               gcount - g0, exp_q.size());
    end
  endtask

  task automatic test_withdraw();
    int g0, a0;
    g0 = gcount;
    a0 = acks;
    ready = 1'b0;
    dma.dmaReq = 1'b1;
    dma.dmaWe  = 1'b0;
    repeat (3) tick();
    dma.dmaReq = 1'b0;
    ready = 1'b1;
    repeat (20) tick();
    total++;
    if (gcount !== g0 || acks !== a0) begin
      bad++;
      $display("FAIL withdraw got grants=%0d acks=%0d required 0 0",
               gcount - g0, acks - a0);
    end
  endtask

  initial begin
    dma.dmaReq = 1'b0;
    dma.dmaWe  = 1'b0;
    dma.dmaA   = '0;
    dma.dmaD   = '0;
    test_reset();
    test_cpu_read();
    test_contention();
    test_dma_write();
    test_busy_strobes();
    test_reset_abort();
    test_ready();
    test_withdraw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
